// File: rtl/demux8_pkg.sv
// Shared definitions for the demux8 serial-to-parallel collector:
// state encoding, slot geometry and the index of the last slot.
package demux8_pkg;

  localparam int SLOT_W    = 3;
  localparam int NUM_SLOTS = 8;

  // Index of the final data slot; accepting into it closes the data phase.
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  // PARITY is only reachable when DEMUX8_PARITY_EN is defined.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/demux8_slot_dec.sv
// 3-to-8 one-hot write-enable decoder: the structural inverse of the mux8
// select chain. sel[2] carries the S1 weight, sel[0] the S3 weight.
module demux8_slot_dec
  import demux8_pkg::*;
(
  input  logic [SLOT_W-1:0]    sel,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] we
);

  // Raise exactly one enable, for the addressed slot, while the strobe is high.
  always_comb begin
    we = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      we[i] = en && (sel == SLOT_W'(i));
    end
  end

endmodule

// File: rtl/demux8_collector.sv
// Serial-to-parallel 1-to-8 demultiplexer with a valid/ack frame handshake.
// Bits are steered into Y0..Y7 in select order; the serial side is stalled
// while a complete frame waits for Y_ACK.
// Optional feature: define DEMUX8_PARITY_EN to add a trailing even-parity
// bit per frame, checked into PAR_ERR. Without it PAR_ERR is tied low.
module demux8_collector
  import demux8_pkg::*;
#(
  parameter bit CLEAR_ON_ACK = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              X,
  input  logic              X_VALID,
  output logic              X_READY,
  output logic [SLOT_W-1:0] S,
  output logic              Y0,
  output logic              Y1,
  output logic              Y2,
  output logic              Y3,
  output logic              Y4,
  output logic              Y5,
  output logic              Y6,
  output logic              Y7,
  output logic              Y_VALID,
  input  logic              Y_ACK,
  output logic              PAR_ERR
);

  state_e                 state_q;
  state_e                 state_d;
  logic [SLOT_W-1:0]      s_q;
  logic [NUM_SLOTS-1:0]   y_q;
  logic [NUM_SLOTS-1:0]   slot_we;
  logic                   accept;
  logic                   slot_accept;
  logic                   frame_done;
  logic                   ack;

  // A bit is taken whenever the source offers one and we are not holding.
  assign accept      = X_VALID && X_READY;
  assign slot_accept = accept && (state_q == COLLECT);
  assign frame_done  = slot_accept && (s_q == LAST_SLOT);
  assign ack         = Y_ACK && (state_q == HOLD);

  demux8_slot_dec u_slot_dec (
    .sel (s_q),
    .en  (slot_accept),
    .we  (slot_we)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Next-state logic: collect 8 bits, optionally one parity bit, then hold.
  // NOTE: state_d defaults to state_q before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
`ifdef DEMUX8_PARITY_EN
        if (frame_done) state_d = PARITY;
`else
        if (frame_done) state_d = HOLD;
`endif
      end
`ifdef DEMUX8_PARITY_EN
      PARITY: begin
        if (accept) state_d = HOLD;
      end
`endif
      HOLD: begin
        if (Y_ACK) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Handshake outputs are decoded from state alone.
  always_comb begin
    X_READY = 1'b1;
    Y_VALID = 1'b0;
    case (state_q)
      HOLD: begin
        X_READY = 1'b0;
        Y_VALID = 1'b1;
      end
      default: ;
    endcase
  end

  // Slot pointer: advances on each stored data bit and wraps after slot 7.
  always_ff @(posedge CLK) begin
    if (RST)              s_q <= '0;
    else if (slot_accept) s_q <= s_q + SLOT_W'(1);
  end

  // Slot register: only the addressed slot takes the incoming bit.
  // NOTE: the slots are reset because zero is their defined visible value
  // after reset, not just an initialisation convenience.
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q <= '0;
    end else if (ack && CLEAR_ON_ACK) begin
      y_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_we[i]) y_q[i] <= X;
      end
    end
  end

`ifdef DEMUX8_PARITY_EN
  logic par_err_q;

  // Even-parity check on the trailing bit; held until the frame is acked.
  always_ff @(posedge CLK) begin
    if (RST)                                par_err_q <= 1'b0;
    else if (accept && state_q == PARITY)   par_err_q <= (^y_q) ^ X;
    else if (ack)                           par_err_q <= 1'b0;
  end

  assign PAR_ERR = par_err_q;
`else
  assign PAR_ERR = 1'b0;
`endif

  assign S  = s_q;
  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];
  assign Y4 = y_q[4];
  assign Y5 = y_q[5];
  assign Y6 = y_q[6];
  assign Y7 = y_q[7];

endmodule

// File: tb/tb_demux8_collector.sv
// Self-checking bench for demux8_collector. Two instances share stimulus:
// dut_a with CLEAR_ON_ACK=1 and dut_b with CLEAR_ON_ACK=0. A frame-level
// model (bit count, slot arrays, parity flag) predicts both.
module tb_demux8_collector;

  localparam int NS = 8;
`ifdef DEMUX8_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0;
  logic x_valid = 1'b0;
  logic y_ack = 1'b0;

  logic       a_ready, a_valid, a_par, b_ready, b_valid, b_par;
  logic [2:0] a_s, b_s;
  logic       a_y0, a_y1, a_y2, a_y3, a_y4, a_y5, a_y6, a_y7;
  logic       b_y0, b_y1, b_y2, b_y3, b_y4, b_y5, b_y6, b_y7;
  logic [7:0] a_y, b_y;

  assign a_y = {a_y7, a_y6, a_y5, a_y4, a_y3, a_y2, a_y1, a_y0};
  assign b_y = {b_y7, b_y6, b_y5, b_y4, b_y3, b_y2, b_y1, b_y0};

  always #5 clk = ~clk;

  demux8_collector #(.CLEAR_ON_ACK(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .X(x), .X_VALID(x_valid), .X_READY(a_ready),
    .S(a_s), .Y0(a_y0), .Y1(a_y1), .Y2(a_y2), .Y3(a_y3), .Y4(a_y4),
    .Y5(a_y5), .Y6(a_y6), .Y7(a_y7), .Y_VALID(a_valid), .Y_ACK(y_ack),
    .PAR_ERR(a_par)
  );

  demux8_collector #(.CLEAR_ON_ACK(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .X(x), .X_VALID(x_valid), .X_READY(b_ready),
    .S(b_s), .Y0(b_y0), .Y1(b_y1), .Y2(b_y2), .Y3(b_y3), .Y4(b_y4),
    .Y5(b_y5), .Y6(b_y6), .Y7(b_y7), .Y_VALID(b_valid), .Y_ACK(y_ack),
    .PAR_ERR(b_par)
  );

  // Reference model: bits accepted in the current frame plus slot contents.
  int         m_cnt = 0;
  logic [7:0] m_ya = '0;
  logic [7:0] m_yb = '0;
  logic       m_par = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] exp_s();
    return (m_cnt < NS) ? 3'(m_cnt) : 3'd0;
  endfunction

  function automatic logic exp_ready();
    return m_cnt < FRAME_LEN;
  endfunction

  function automatic logic exp_valid();
    return m_cnt == FRAME_LEN;
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic tick(input logic t_x, input logic t_v, input logic t_ack,
                      input logic t_rst);
    x       = t_x;
    x_valid = t_v;
    y_ack   = t_ack;
    rst     = t_rst;
    if (t_rst) begin
      m_cnt = 0; m_ya = '0; m_yb = '0; m_par = 1'b0;
    end else if (m_cnt < NS) begin
      if (t_v) begin
        m_ya[m_cnt[2:0]] = t_x;
        m_yb[m_cnt[2:0]] = t_x;
        m_cnt++;
      end
    end else if (m_cnt < FRAME_LEN) begin
      if (t_v) begin
        m_par = (^m_ya) ^ t_x;
        m_cnt++;
      end
    end else if (t_ack) begin
      m_cnt = 0; m_par = 1'b0; m_ya = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (a_s !== 3'd0 || b_s !== 3'd0) begin
      errors++; $display("FAIL reset_s: got %0d/%0d expected 0", a_s, b_s);
    end
    checks++;
    if (a_y !== 8'h00 || b_y !== 8'h00) begin
      errors++; $display("FAIL reset_slots: got %h/%h expected 00", a_y, b_y);
    end
    checks++;
    if ({a_valid, a_ready, a_par} !== 3'b010) begin
      errors++; $display("FAIL reset_handshake: got valid,ready,par=%b expected 010", {a_valid, a_ready, a_par});
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] bits;
    bits = 8'h4D;  // Y0..Y7 = 1,0,1,1,0,0,1,0
    for (int i = 0; i < NS; i++) begin
      tick(bits[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (a_s !== exp_s() || a_y !== m_ya || a_valid !== exp_valid()) begin
        errors++;
        $display("FAIL basic_step%0d: got s=%0d y=%h v=%b expected s=%0d y=%h v=%b",
                 i, a_s, a_y, a_valid, exp_s(), m_ya, exp_valid());
      end
    end
    if (FRAME_LEN > NS) tick(^bits, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_y !== 8'h4D || b_y !== 8'h4D) begin
      errors++; $display("FAIL basic_frame: got %h/%h expected 4d", a_y, b_y);
    end
    checks++;
    if (a_valid !== 1'b1 || a_ready !== 1'b0 || a_par !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got valid=%b ready=%b par=%b expected 1 0 0", a_valid, a_ready, a_par);
    end
  endtask

  task automatic test_hold_ignore();
    for (int k = 0; k < 5; k++) begin
      tick(1'(k), 1'b1, 1'b0, 1'b0);
      checks++;
      if (a_y !== 8'h4D || a_s !== 3'd0 || a_valid !== 1'b1) begin
        errors++; $display("FAIL hold_ignore%0d: got y=%h s=%0d v=%b expected 4d 0 1", k, a_y, a_s, a_valid);
      end
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_par !== 1'b0) begin
      errors++; $display("FAIL ack_handshake: got valid=%b ready=%b par=%b expected 0 1 0", a_valid, a_ready, a_par);
    end
    checks++;
    if (a_y !== 8'h00 || b_y !== 8'h4D || a_s !== 3'd0) begin
      errors++; $display("FAIL ack_slots: got a=%h b=%h s=%0d expected 00 4d 0", a_y, b_y, a_s);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] r;
    int acc;
    r   = 8'($urandom);
    acc = 0;
    for (int c = 0; c < 15; c++) begin
      logic v;
      v = (c % 2 == 0);
      tick(r[acc[2:0]], v, 1'b0, 1'b0);
      if (v) acc++;
      checks++;
      if (a_s !== exp_s() || a_valid !== exp_valid() || a_ready !== exp_ready()) begin
        errors++;
        $display("FAIL gapped_c%0d: got s=%0d v=%b r=%b expected s=%0d v=%b r=%b",
                 c, a_s, a_valid, a_ready, exp_s(), exp_valid(), exp_ready());
      end
    end
    if (FRAME_LEN > NS) tick(^r, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_valid !== 1'b1 || a_y !== r || b_y !== r) begin
      errors++; $display("FAIL gapped_frame: got v=%b y=%h/%h expected 1 %h", a_valid, a_y, b_y, r);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 4; i++) tick(1'($urandom), 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (a_s !== 3'd0 || a_y !== 8'h00 || b_y !== 8'h00 || a_valid !== 1'b0) begin
      errors++; $display("FAIL midreset: got s=%0d y=%h/%h v=%b expected 0 00 00 0", a_s, a_y, b_y, a_valid);
    end
    for (int i = 0; i < FRAME_LEN; i++) tick((i < NS), 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_y !== 8'hFF || b_y !== 8'hFF || a_valid !== 1'b1 || a_par !== 1'b0) begin
      errors++; $display("FAIL ones_frame: got y=%h/%h v=%b p=%b expected ff ff 1 0", a_y, b_y, a_valid, a_par);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (a_y !== 8'h00 || b_y !== 8'hFF) begin
      errors++; $display("FAIL clear_on_ack: got a=%h b=%h expected 00 ff", a_y, b_y);
    end
    for (int i = 0; i < NS; i++) begin
      logic [7:0] e;
      e = 8'hFF << (i + 1);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (b_y !== e) begin
        errors++; $display("FAIL hold_overwrite%0d: got %h expected %h", i, b_y, e);
      end
    end
    if (FRAME_LEN > NS) tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

`ifdef DEMUX8_PARITY_EN
  task automatic test_parity();
    for (int p = 0; p < 2; p++) begin
      logic [7:0] f;
      f = 8'h03;  // Y0..Y7 = 1,1,0,0,0,0,0,0
      for (int i = 0; i < NS; i++) tick(f[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_s !== 3'd0) begin
        errors++; $display("FAIL parity_wait%0d: got v=%b r=%b s=%0d expected 0 1 0", p, a_valid, a_ready, a_s);
      end
      tick(1'(p), 1'b1, 1'b0, 1'b0);
      checks++;
      if (a_valid !== 1'b1 || a_par !== 1'(p) || b_par !== 1'(p) || a_y !== f) begin
        errors++; $display("FAIL parity_result%0d: got v=%b par=%b/%b y=%h expected 1 %0d %h", p, a_valid, a_par, b_par, a_y, p, f);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (a_par !== 1'b0) begin
        errors++; $display("FAIL parity_clear%0d: got %b expected 0", p, a_par);
      end
    end
  endtask
`endif

  task automatic test_ack_held();
    logic [7:0] r;
    r = 8'($urandom);
    for (int i = 0; i < FRAME_LEN; i++) begin
      tick((i < NS) ? r[i[2:0]] : ^r, 1'b1, 1'b1, 1'b0);
      checks++;
      if (a_valid !== exp_valid() || a_s !== exp_s()) begin
        errors++; $display("FAIL ack_held_step%0d: got v=%b s=%0d expected v=%b s=%0d", i, a_valid, a_s, exp_valid(), exp_s());
      end
    end
    tick(~r[0], 1'b1, 1'b1, 1'b0);
    checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_s !== 3'd0 || b_y !== r) begin
      errors++; $display("FAIL ack_edge_bit: got v=%b r=%b s=%0d b=%h expected 0 1 0 %h", a_valid, a_ready, a_s, b_y, r);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [19:0] got, exp;
      tick(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 49) == 0));
      got = {a_s, a_ready, a_valid, a_par, a_y, b_y[7:0]};
      exp = {exp_s(), exp_ready(), exp_valid(), m_par, m_ya, m_yb};
      checks++;
      if (got !== exp || {b_s, b_ready, b_valid, b_par} !== {exp_s(), exp_ready(), exp_valid(), m_par}) begin
        errors++; $display("FAIL random_c%0d: got %h expected %h (b s/r/v/p=%0d%b%b%b)", c, got, exp, b_s, b_ready, b_valid, b_par);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hold_ignore();
    test_gapped();
    test_reset_midframe();
`ifdef DEMUX8_PARITY_EN
    test_parity();
`endif
    test_ack_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
